// File: rtl/addition_unit_if.sv
// Operand/result bundle for the ALU adder lane.
// The slave side is the adder; the master side supplies operands and consumes results.
interface addition_unit_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CarryIN;
   logic [WIDTH-1:0] Y;
   logic             CarryOUT;
   logic             overflow;
   logic             zero;
   logic             negative;
   logic             out_valid;

   modport master (
      output in_valid, A, B, CarryIN,
      input  Y, CarryOUT, overflow, zero, negative, out_valid
   );

   modport slave (
      input  in_valid, A, B, CarryIN,
      output Y, CarryOUT, overflow, zero, negative, out_valid
   );
endinterface

// File: rtl/addition_unit.sv
// Registered ripple-carry adder: A + B + CarryIN with carry, signed overflow,
// zero and negative flags, one cycle of latency, results held while idle.
module addition_unit #(
   parameter int unsigned WIDTH = 4
) (
   input logic            clk,
   input logic            rst,
   addition_unit_if.slave bus
);
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   logic [WIDTH-1:0] y_d, y_q;
   logic             carry_d, carry_q;
   logic             ovf_d, ovf_q;
   logic             zero_d, zero_q;
   logic             neg_d, neg_q;
   logic             valid_d, valid_q;

   // Carry is threaded through a block-local variable so each bit sees the
   // carry out of the bit below it.
   always_comb begin
      logic c;
      logic g;
      logic p;
      sum = '0;
      c   = bus.CarryIN;
      g   = 1'b0;
      p   = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         g      = bus.A[i] & bus.B[i];
         p      = bus.A[i] ^ bus.B[i];
         sum[i] = p ^ c;
         c      = g | (p & c);
      end
      carry_out = c;
   end

   always_comb begin
      y_d     = y_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      valid_d = bus.in_valid;
      if (bus.in_valid) begin
         y_d     = sum;
         carry_d = carry_out;
         ovf_d   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         zero_d  = (sum == '0);
         neg_d   = sum[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         valid_q <= valid_d;
      end
   end

   assign bus.Y         = y_q;
   assign bus.CarryOUT  = carry_q;
   assign bus.overflow  = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.negative  = neg_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_addition_unit.sv
// Scoreboard bench for addition_unit: driver queues expected results, a
// negedge monitor checks each presented result and the hold behaviour when idle.
module tb_addition_unit;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;

   typedef struct {
      logic [3:0] y;
      logic       c;
      logic       ov;
      logic       z;
      logic       n;
      int         due;
   } exp_t;

   exp_t sb[$];
   exp_t last;

   addition_unit_if #(.WIDTH(4)) bus ();
   addition_unit #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [3:0] ey, input logic ec, input logic eo,
                        input logic ez, input logic en);
      exp_t e;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.A        = a;
      bus.B        = b;
      bus.CarryIN  = cin;
      e.y = ey; e.c = ec; e.ov = eo; e.z = ez; e.n = en;
      e.due = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.A        = $urandom_range(0, 15);
      bus.B        = $urandom_range(0, 15);
      bus.CarryIN  = 1'($urandom_range(0, 1));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("latency_cycle", cyc, e.due);
               chk("Y", int'(bus.Y), int'(e.y));
               chk("CarryOUT", int'(bus.CarryOUT), int'(e.c));
               chk("overflow", int'(bus.overflow), int'(e.ov));
               chk("zero", int'(bus.zero), int'(e.z));
               chk("negative", int'(bus.negative), int'(e.n));
               last = e;
            end
         end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
               chk("missing_out_valid", 0, 1);
               void'(sb.pop_front());
            end
            chk("hold_Y", int'(bus.Y), int'(last.y));
            chk("hold_CarryOUT", int'(bus.CarryOUT), int'(last.c));
            chk("hold_overflow", int'(bus.overflow), int'(last.ov));
            chk("hold_zero", int'(bus.zero), int'(last.z));
            chk("hold_negative", int'(bus.negative), int'(last.n));
         end
      end
   end

   initial begin
      logic [4:0] s;
      logic [3:0] a, b;
      logic       cin;
      int         wait_cyc;

      last = '{y: 4'd0, c: 1'b0, ov: 1'b0, z: 1'b0, n: 1'b0, due: 0};
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.A        = 4'b1111;
      bus.B        = 4'b1111;
      bus.CarryIN  = 1'b0;

      // Two reset edges with a valid operation presented: it must be discarded.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_Y", int'(bus.Y), 0);
      chk("rst_CarryOUT", int'(bus.CarryOUT), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_zero", int'(bus.zero), 0);
      chk("rst_negative", int'(bus.negative), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);

      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      mon_en       = 1'b1;

      //      A        B        Cin   Y        C     OV    Z     N
      issue(4'b0110, 4'b0010, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
      issue(4'b0010, 4'b0110, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
      issue(4'b1100, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
      idle();
      idle();
      issue(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
      issue(4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
      issue(4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
      issue(4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      idle();
      idle();

      for (int i = 0; i < 512; i++) begin
         a   = 4'(i);
         b   = 4'(i >> 4);
         cin = 1'(i >> 8);
         s   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
         issue(a, b, cin, s[3:0], s[4],
               (a[3] == b[3]) && (s[3] != a[3]), (s[3:0] == 4'd0), s[3]);
         if ($urandom_range(0, 7) == 0) idle();
      end
      idle();
      idle();

      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 20) begin
         @(posedge clk);
         wait_cyc++;
      end
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
